// File: rtl/wb_lsu_master.sv
// -----------------------------------------------------------------------------
// wb_lsu_master
// Wishbone pipelined-mode bus master for core load/store traffic. Each accepted
// byte/half/word request becomes a single-beat Wishbone cycle. Load data comes
// back lane-aligned and sign- or zero-extended. Misaligned requests complete
// with an error and no bus cycle is issued.
//
// Optional feature: define WB_TIMEOUT_EN to add a bus watchdog. When it is
// enabled, a cycle that is open for TIMEOUT_CYCLES cycles without an ack is
// aborted and completes with an error.
//
// Ports
//   i_clk, i_reset      clock; synchronous active-high reset
//   i_req .. i_unsigned core request (accepted when i_req && o_ready)
//   o_ready             high while idle
//   o_valid/o_rdata/o_err  one-cycle completion pulse with load data / error
//   o_wb_*              Wishbone master outputs (cyc, stb, we, addr, data, sel)
//   i_wb_data/stall/ack Wishbone slave responses
// -----------------------------------------------------------------------------
module wb_lsu_master #(
    parameter int XLEN = 32
`ifdef WB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_req,
    input  logic            i_we,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [1:0]      i_size,
    input  logic            i_unsigned,
    output logic            o_ready,
    output logic            o_valid,
    output logic [XLEN-1:0] o_rdata,
    output logic            o_err,
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [XLEN-1:0] o_wb_addr,
    output logic [XLEN-1:0] o_wb_data,
    output logic [3:0]      o_wb_sel,
    input  logic [XLEN-1:0] i_wb_data,
    input  logic            i_wb_stall,
    input  logic            i_wb_ack
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0] state_r;
    logic [1:0] lane_r;
    logic [1:0] size_r;
    logic       unsigned_r;
    logic       we_r;
    logic       accept_s;
    logic       misaligned_s;
    logic       timeout_s;

    // Half needs an even address, word (and the 11 encoding) a word-aligned one.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = lane[0];
            default: is_misaligned = (lane != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   lane_sel = 4'b0001 << lane;
            2'b01:   lane_sel = 4'b0011 << {lane[1], 1'b0};
            default: lane_sel = 4'b1111;
        endcase
    endfunction

    // Store data is replicated so the selected lanes carry it wherever they are.
    function automatic logic [XLEN-1:0] lane_wdata(input logic [1:0] size, input logic [XLEN-1:0] data);
        case (size)
            2'b00:   lane_wdata = {4{data[7:0]}};
            2'b01:   lane_wdata = {2{data[15:0]}};
            default: lane_wdata = data;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] load_extend(input logic [1:0] size, input logic [1:0] lane,
                                                   input logic uns, input logic [XLEN-1:0] data);
        logic [XLEN-1:0] shifted;
        shifted = data >> {lane, 3'b000};
        case (size)
            2'b00:   load_extend = uns ? {24'h000000, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_extend = uns ? {16'h0000, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
            default: load_extend = shifted;
        endcase
    endfunction

    // Request handshake and alignment classification of the incoming request.
    always_comb begin
        accept_s     = i_req && o_ready;
        misaligned_s = is_misaligned(i_size, i_addr[1:0]);
    end

`ifdef WB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_r;

    // Watchdog counter: cleared on accept, advances every cycle a bus cycle is open.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tmo_cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            tmo_cnt_r <= {CNT_W{1'b0}};
        end else if (o_wb_cyc) begin
            tmo_cnt_r <= tmo_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // The abort fires on the last allowed cycle so cyc is high exactly TIMEOUT_CYCLES cycles.
    always_comb begin
        timeout_s = o_wb_cyc && (tmo_cnt_r == CNT_LAST);
    end
`else
    // Without the watchdog the master waits for ack indefinitely.
    always_comb begin
        timeout_s = 1'b0;
    end
`endif

    // Main control FSM; every core-facing and bus-facing output is a register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r    <= ST_IDLE;
            lane_r     <= 2'b00;
            size_r     <= 2'b00;
            unsigned_r <= 1'b0;
            we_r       <= 1'b0;
            o_ready    <= 1'b1;
            o_valid    <= 1'b0;
            o_err      <= 1'b0;
            o_rdata    <= {XLEN{1'b0}};
            o_wb_cyc   <= 1'b0;
            o_wb_stb   <= 1'b0;
            o_wb_we    <= 1'b0;
            o_wb_addr  <= {XLEN{1'b0}};
            o_wb_data  <= {XLEN{1'b0}};
            o_wb_sel   <= 4'b0000;
        end else begin
            o_valid <= 1'b0;
            o_err   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        lane_r     <= i_addr[1:0];
                        size_r     <= i_size;
                        unsigned_r <= i_unsigned;
                        we_r       <= i_we;
                        if (misaligned_s) begin
                            // Complete immediately with an error and stay ready.
                            o_valid <= 1'b1;
                            o_err   <= 1'b1;
                            o_rdata <= {XLEN{1'b0}};
                        end else begin
                            o_wb_cyc  <= 1'b1;
                            o_wb_stb  <= 1'b1;
                            o_wb_we   <= i_we;
                            o_wb_addr <= {i_addr[XLEN-1:2], 2'b00};
                            o_wb_data <= lane_wdata(i_size, i_wdata);
                            o_wb_sel  <= lane_sel(i_size, i_addr[1:0]);
                            o_ready   <= 1'b0;
                            state_r   <= ST_REQ;
                        end
                    end
                end
                ST_REQ, ST_WAIT: begin
                    // An ack is honoured in either phase, even one raised while stalled.
                    if (i_wb_ack || timeout_s) begin
                        o_wb_cyc <= 1'b0;
                        o_wb_stb <= 1'b0;
                        o_wb_we  <= 1'b0;
                        o_valid  <= 1'b1;
                        o_err    <= ~i_wb_ack;
                        o_ready  <= 1'b1;
                        state_r  <= ST_IDLE;
                        if (i_wb_ack && !we_r) begin
                            o_rdata <= load_extend(size_r, lane_r, unsigned_r, i_wb_data);
                        end else begin
                            o_rdata <= {XLEN{1'b0}};
                        end
                    end else if ((state_r == ST_REQ) && !i_wb_stall) begin
                        o_wb_stb <= 1'b0;
                        state_r  <= ST_WAIT;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    o_ready  <= 1'b1;
                    o_wb_cyc <= 1'b0;
                    o_wb_stb <= 1'b0;
                    o_wb_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_lsu_master.sv
// -----------------------------------------------------------------------------
// tb_wb_lsu_master
// Scoreboard bench for wb_lsu_master. The driver pushes the expected completion,
// bus beat and slave timing for each request into queues. A slave model answers
// the bus from a small memory. A monitor pops and compares on every o_valid.
// Define WB_TIMEOUT_EN to also exercise the watchdog abort.
// -----------------------------------------------------------------------------
module tb_wb_lsu_master;

    localparam int TMO = 8;

    typedef struct { logic [31:0] rdata; logic err; int lat; int acc; } resp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] sel; logic we; } bus_t;
    typedef struct { int stall; int dly; } scfg_t;

    logic        clk = 1'b0;
    logic        i_reset, i_req, i_we, i_unsigned;
    logic [31:0] i_addr, i_wdata;
    logic [1:0]  i_size;
    logic        o_ready, o_valid, o_err;
    logic [31:0] o_rdata;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [31:0] o_wb_addr, o_wb_data;
    logic [3:0]  o_wb_sel;
    logic [31:0] i_wb_data;
    logic        i_wb_stall, i_wb_ack;

    int    errors = 0;
    int    checks = 0;
    int    cyc_cnt = 0;
    resp_t resp_q[$];
    bus_t  bus_q[$];
    scfg_t slave_q[$];
    logic [31:0] mem [16];

    wb_lsu_master #(
        .XLEN(32)
`ifdef WB_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TMO)
`endif
    ) dut (
        .i_clk(clk), .i_reset(i_reset), .i_req(i_req), .i_we(i_we), .i_addr(i_addr),
        .i_wdata(i_wdata), .i_size(i_size), .i_unsigned(i_unsigned), .o_ready(o_ready),
        .o_valid(o_valid), .o_rdata(o_rdata), .o_err(o_err), .o_wb_cyc(o_wb_cyc),
        .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
        .o_wb_sel(o_wb_sel), .i_wb_data(i_wb_data), .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc_cnt);
    endtask

    // ---------------- reference model: arithmetic on the access rules --------
    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] addr, input logic [1:0] size, input logic uns);
        longint w, v, span;
        int nb;
        nb   = nbytes(size);
        span = longint'(1) << (8 * nb);
        w    = longint'(mem[addr[5:2]]);
        v    = (w >> (8 * int'(addr % 4))) % span;
        if (!uns && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    // ---------------- driver ----------------
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns, input int stall, input int dly,
                         input bit exp_resp, output int acc);
        int guard, nb;
        bit mis;
        resp_t r;
        bus_t  b;
        scfg_t s;
        i_req = 1'b1; i_we = we; i_addr = addr; i_wdata = wdata; i_size = size; i_unsigned = uns;
        guard = 0;
        while (o_ready !== 1'b1 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        acc = cyc_cnt;
        if (guard >= 300) begin
            fail("ready_wait_timeout");
            i_req = 1'b0;
            return;
        end
        nb  = nbytes(size);
        mis = (addr % nb) != 0;
        r.acc = cyc_cnt; r.err = mis; r.rdata = 32'h0;
        if (mis) r.lat = 1;
        else if (dly < 0) begin r.err = 1'b1; r.lat = TMO + 1; end
        else begin
            r.lat = 2 + stall + dly;
            if (!we) r.rdata = exp_load(addr, size, uns);
        end
        if (exp_resp) resp_q.push_back(r);
        if (!mis) begin
            b.addr = addr - (addr % 4);
            b.sel  = 4'(((1 << nb) - 1) << (addr % 4));
            b.data = (nb == 1) ? (wdata % 256) * 32'h01010101 :
                     (nb == 2) ? (wdata % 65536) * 32'h00010001 : wdata;
            b.we   = we;
            bus_q.push_back(b);
            s.stall = stall; s.dly = dly;
            slave_q.push_back(s);
        end
        @(negedge clk);
        i_req = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (resp_q.size() != 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) fail("drain_timeout");
        @(negedge clk);
    endtask

    // ---------------- slave model (drives on the falling edge) ----------------
    bit    in_req = 1'b0, pending = 1'b0;
    int    stall_left = 0, ack_left = 0;
    scfg_t cur;
    bus_t  bexp;

    always @(negedge clk) begin
        i_wb_ack  = 1'b0;
        i_wb_data = $urandom;
        if (o_wb_cyc !== 1'b1) begin
            in_req = 1'b0; pending = 1'b0; i_wb_stall = 1'b0;
        end else begin
            if (!in_req) begin
                in_req = 1'b1;
                if (slave_q.size() > 0) cur = slave_q.pop_front();
                else begin fail("unexpected_cyc"); cur.stall = 0; cur.dly = 1; end
                stall_left = cur.stall;
            end
            if (pending) begin
                chk("stb_dropped", {31'h0, o_wb_stb}, 32'h0);
                i_wb_stall = 1'b0;
            end else begin
                chk("stb_high", {31'h0, o_wb_stb}, 32'h1);
                if (bus_q.size() == 0) fail("unexpected_stb");
                else begin
                    bexp = bus_q[0];
                    chk("wb_addr", o_wb_addr, bexp.addr);
                    chk("wb_sel", {28'h0, o_wb_sel}, {28'h0, bexp.sel});
                    chk("wb_data", o_wb_data, bexp.data);
                    chk("wb_we", {31'h0, o_wb_we}, {31'h0, bexp.we});
                end
                if (stall_left > 0) begin
                    i_wb_stall = 1'b1;
                    stall_left--;
                end else begin
                    i_wb_stall = 1'b0;
                    pending = 1'b1;
                    ack_left = cur.dly;
                    if (bus_q.size() > 0) void'(bus_q.pop_front());
                end
            end
            if (pending && ack_left == 0) begin
                i_wb_ack  = 1'b1;
                i_wb_data = mem[o_wb_addr[5:2]];
            end else if (pending && ack_left > 0) begin
                ack_left--;
            end
        end
    end

    // ---------------- completion monitor ----------------
    resp_t rx;
    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            if (resp_q.size() == 0) fail("unexpected_valid");
            else begin
                rx = resp_q.pop_front();
                chk("rdata", o_rdata, rx.rdata);
                chk("err", {31'h0, o_err}, {31'h0, rx.err});
                chk("latency", 32'(cyc_cnt - rx.acc), 32'(rx.lat));
                chk("ready_at_valid", {31'h0, o_ready}, 32'h1);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int a1, a2, acc;
        i_reset = 1'b1; i_req = 1'b0; i_we = 1'b0; i_addr = 32'h0; i_wdata = 32'h0;
        i_size = 2'd0; i_unsigned = 1'b0; i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_data = 32'h0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[4] = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        i_reset = 1'b0;

        // Reset state.
        chk("rst_ready", {31'h0, o_ready}, 32'h1);
        chk("rst_ctrl", {27'h0, o_valid, o_err, o_wb_cyc, o_wb_stb, o_wb_we}, 32'h0);
        chk("rst_rdata", o_rdata, 32'h0);
        chk("rst_wb_addr", o_wb_addr, 32'h0);
        chk("rst_wb_data", o_wb_data, 32'h0);
        chk("rst_wb_sel", {28'h0, o_wb_sel}, 32'h0);

        // Word load, zero stall, ack one cycle after stb.
        issue(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, 1, 1'b1, acc);
        drain();

        // Signed and unsigned byte loads from the top lane.
        mem[4] = 32'h80FF0000;
        issue(1'b0, 32'h13, 32'h0, 2'd0, 1'b0, 0, 1, 1'b1, acc);
        issue(1'b0, 32'h13, 32'h0, 2'd0, 1'b1, 0, 1, 1'b1, acc);
        drain();

        // Half store with three stall cycles.
        issue(1'b1, 32'h22, 32'h0000ABCD, 2'd1, 1'b0, 3, 1, 1'b1, acc);
        drain();

        // Misaligned word load: error, no bus cycle.
        issue(1'b0, 32'h06, 32'h0, 2'd2, 1'b0, 0, 1, 1'b1, acc);
        drain();

        // Back-to-back word loads.
        issue(1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 0, 1, 1'b1, a1);
        issue(1'b0, 32'h4, 32'h0, 2'd2, 1'b0, 0, 1, 1'b1, a2);
        chk("b2b_accept_gap", 32'(a2 - a1), 32'd3);
        drain();

        // Ack in the same cycle the strobe is taken.
        issue(1'b0, 32'h2A, 32'h0, 2'd1, 1'b0, 0, 0, 1'b1, acc);
        drain();

`ifdef WB_TIMEOUT_EN
        // Slave never acks: watchdog abort.
        issue(1'b0, 32'h14, 32'h0, 2'd2, 1'b0, 0, -1, 1'b1, acc);
        drain();
        chk("tmo_cyc_low", {31'h0, o_wb_cyc}, 32'h0);
`endif

        // Reset in the middle of a waiting cycle: no completion must appear.
        issue(1'b0, 32'h30, 32'h0, 2'd2, 1'b0, 0, -1, 1'b0, acc);
        repeat (3) @(negedge clk);
        chk("cyc_before_reset", {31'h0, o_wb_cyc}, 32'h1);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        chk("reset_mid_cyc", {29'h0, o_wb_cyc, o_wb_stb, o_valid}, 32'h0);
        chk("reset_mid_ready", {31'h0, o_ready}, 32'h1);
        repeat (12) @(negedge clk);

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom,
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b1, acc);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();
        repeat (5) @(negedge clk);
        chk("resp_q_empty", 32'(resp_q.size()), 32'd0);
        chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
        chk("slave_q_empty", 32'(slave_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "simulation time limit reached");
    end

endmodule
